// File: rtl/cp0_ctrl.sv
// ============================================================================
// Module   : cp0_ctrl
// Brief    : MIPS CP0 controller. Holds BadVAddr, Count, Compare, Status,
//            Cause, EPC, PRId and Config; generates masked interrupt
//            requests, a prescaled Count/Compare timer and exception/ERET
//            pipeline redirects.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module cp0_ctrl #(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 2,
    parameter int          TIMER_LINE = 5,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] PRID_VAL   = 32'h004C_0102
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [31:0]           wdata,
    input  logic [4:0]            raddr,
    output logic [31:0]           rdata,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_bd,
    input  logic [31:0]           exc_badvaddr,
    input  logic                  eret,
    output logic                  int_req,
    output logic                  flush,
    output logic [31:0]           new_pc,
    output logic [31:0]           status,
    output logic [31:0]           cause,
    output logic [31:0]           epc
);

    // Register numbers
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam logic [31:0] CONFIG_VAL  = 32'h0000_8000;
    localparam logic [15:0] STATUS_HI   = 16'h0040;   // BEV=1, fixed
    localparam logic [3:0]  DIV_LAST    = 4'(COUNT_DIV - 1);

    // State registers
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q,    count_d;
    logic [31:0] compare_q,  compare_d;
    logic [31:0] epc_q,      epc_d;
    logic [3:0]  presc_q,    presc_d;
    logic        inc_q,      inc_d;      // Count advanced on the last edge
    logic [7:0]  im_q,       im_d;
    logic        exl_q,      exl_d;
    logic        ie_q,       ie_d;
    logic        bd_q,       bd_d;
    logic        ti_q,       ti_d;
    logic [5:0]  iphw_q,     iphw_d;
    logic [1:0]  ipsw_q,     ipsw_d;
    logic [4:0]  exccode_q,  exccode_d;

    logic [5:0]  w_int_ext;
    logic [5:0]  w_ti_vec;
    logic [7:0]  w_ip;
    logic        w_mtc0;

    // Zero-extend the external interrupt lines onto the six hardware IP bits
    for (genvar gi = 0; gi < 6; gi++) begin : g_int_map
        if (gi < NUM_HW_INT) begin : g_used
            assign w_int_ext[gi] = int_i[gi];
        end else begin : g_unused
            assign w_int_ext[gi] = 1'b0;
        end
    end

    // The timer pending bit is folded onto its hardware IP line on read-out,
    // so int_req reacts on the same edge that TI is set.
    assign w_ti_vec = {5'b0, ti_q} << TIMER_LINE;
    assign w_ip     = {iphw_q | w_ti_vec, ipsw_q};

    assign status = {STATUS_HI, im_q, 6'b0, exl_q, ie_q};
    assign cause  = {bd_q, ti_q, 14'b0, w_ip, 1'b0, exccode_q, 2'b0};
    assign epc    = epc_q;

    assign int_req = ie_q & ~exl_q & (|(w_ip & im_q));
    assign flush   = rst & (exc_valid | eret);
    assign new_pc  = exc_valid ? EXC_VECTOR : epc_q;

    // MTC0 only takes effect in cycles without an exception or ERET
    assign w_mtc0 = we & ~exc_valid & ~eret;

    // MFC0 read mux (no write bypass)
    always_comb begin
        rdata = 32'h0;
        case (raddr)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count_q;
            REG_COMPARE:  rdata = compare_q;
            REG_STATUS:   rdata = status;
            REG_CAUSE:    rdata = cause;
            REG_EPC:      rdata = epc_q;
            REG_PRID:     rdata = PRID_VAL;
            REG_CONFIG:   rdata = CONFIG_VAL;
            default:      rdata = 32'h0;
        endcase
    end

    // Next-state: timer, interrupt sampling, exception/ERET, then MTC0
    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        epc_d      = epc_q;
        presc_d    = presc_q;
        inc_d      = 1'b0;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        iphw_d     = w_int_ext;
        ipsw_d     = ipsw_q;
        exccode_d  = exccode_q;

        // Prescaled Count; TI is raised one edge after the matching value lands
        if (presc_q == DIV_LAST) begin
            presc_d = 4'd0;
            count_d = count_q + 32'd1;
            inc_d   = 1'b1;
        end else begin
            presc_d = presc_q + 4'd1;
        end
        if (inc_q && (count_q == compare_q)) begin
            ti_d = 1'b1;
        end

        if (exc_valid) begin
            // Nested exceptions keep the original return address
            if (!exl_q) begin
                epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                bd_d  = exc_bd;
            end
            exccode_d = exc_code;
            exl_d     = 1'b1;
            if ((exc_code == 5'd4) || (exc_code == 5'd5)) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (eret) begin
            exl_d = 1'b0;
        end else if (w_mtc0) begin
            case (waddr)
                REG_COUNT: begin
                    count_d = wdata;
                    presc_d = 4'd0;
                    inc_d   = 1'b0;
                end
                REG_COMPARE: begin
                    compare_d = wdata;
                    ti_d      = 1'b0;
                end
                REG_STATUS: begin
                    im_d  = wdata[15:8];
                    exl_d = wdata[1];
                    ie_d  = wdata[0];
                end
                REG_CAUSE: ipsw_d = wdata[9:8];
                REG_EPC:   epc_d  = wdata;
                default: ;
            endcase
        end
    end

    // State update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            badvaddr_q <= 32'h0;
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            epc_q      <= 32'h0;
            presc_q    <= 4'd0;
            inc_q      <= 1'b0;
            im_q       <= 8'h0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            iphw_q     <= 6'h0;
            ipsw_q     <= 2'h0;
            exccode_q  <= 5'h0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            presc_q    <= presc_d;
            inc_q      <= inc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            iphw_q     <= iphw_d;
            ipsw_q     <= ipsw_d;
            exccode_q  <= exccode_d;
        end
    end

endmodule

`default_nettype wire
